// File: rtl/hangman_pkg.sv
// hangman_pkg: game state and guess result encodings shared by the controller, renderer and score logic
package hangman_pkg;
  typedef enum logic [1:0] {START = 2'd0, INGAME = 2'd1, WINGAME = 2'd2, LOSTGAME = 2'd3} game_state_e;
  typedef enum logic [1:0] {HIT = 2'd0, MISS = 2'd1, REPEAT = 2'd2, BAD = 2'd3} result_e;
endpackage

// File: rtl/hangman_guess_eval.sv
// hangman_guess_eval: combinational classifier for one letter guess against the current round
module hangman_guess_eval import hangman_pkg::*; #(
  parameter int NUM_LETTERS = 26,
  parameter int MAX_WRONG = 10,
  localparam int LW = $clog2(NUM_LETTERS + 1),
  localparam int CW = $clog2(MAX_WRONG + 1)
) (
  input  logic [LW-1:0]          load_x,
  input  logic [NUM_LETTERS-1:0] guessed_mask,
  input  logic [NUM_LETTERS-1:0] word_mask,
  input  logic [CW-1:0]          lives,
  input  game_state_e            state,
  output result_e                result,
  output logic [NUM_LETTERS-1:0] next_guessed,
  output logic                   win_next,
  output logic                   lose_next
);
  logic [NUM_LETTERS-1:0] bit_x;
  logic is_letter, seen, in_word;
  // codes at or above NUM_LETTERS shift the one-hot out entirely
  always_comb begin
    bit_x = {{(NUM_LETTERS-1){1'b0}}, 1'b1} << load_x;
    is_letter = load_x < LW'(NUM_LETTERS);
    seen = |(bit_x & guessed_mask);
    in_word = |(bit_x & word_mask);
    next_guessed = guessed_mask | bit_x;
    win_next = ~|(word_mask & ~next_guessed);
    lose_next = lives == CW'(1);
    result = (!is_letter || state != INGAME) ? BAD : seen ? REPEAT : in_word ? HIT : MISS;
  end
endmodule

// File: rtl/hangman_game_ctrl.sv
// hangman_game_ctrl: hangman round FSM holding word/guess masks, lives and result pulses
module hangman_game_ctrl import hangman_pkg::*; #(
  parameter int NUM_LETTERS = 26,
  parameter int MAX_WRONG = 10,
  localparam int LW = $clog2(NUM_LETTERS + 1),
  localparam int CW = $clog2(MAX_WRONG + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [LW-1:0]          load_x,
  input  logic [NUM_LETTERS-1:0] mask,
  output logic [1:0]             game_state,
  output logic [NUM_LETTERS-1:0] guessed_mask,
  output logic [NUM_LETTERS-1:0] reveal_mask,
  output logic [CW-1:0]          lives,
  output logic                   hit,
  output logic                   miss,
  output logic                   repeat_guess,
  output logic                   bad_cmd
);
  game_state_e state, state_d;
  logic [NUM_LETTERS-1:0] word_mask, word_d, guessed_d, next_guessed;
  logic [CW-1:0] lives_d;
  logic [3:0] pulse, pulse_d;
  result_e result;
  logic win_next, lose_next, is_start;
  hangman_guess_eval #(.NUM_LETTERS(NUM_LETTERS), .MAX_WRONG(MAX_WRONG)) u_eval (
    .load_x(load_x), .guessed_mask(guessed_mask), .word_mask(word_mask), .lives(lives),
    .state(state), .result(result), .next_guessed(next_guessed),
    .win_next(win_next), .lose_next(lose_next)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= START;
      word_mask <= '0;
      guessed_mask <= '0;
      lives <= CW'(MAX_WRONG);
      pulse <= '0;
    end else begin
      state <= state_d;
      word_mask <= word_d;
      guessed_mask <= guessed_d;
      lives <= lives_d;
      pulse <= pulse_d;
    end
  end
  // pulse bits: {hit, miss, repeat_guess, bad_cmd}
  always_comb begin
    state_d = state;
    word_d = word_mask;
    guessed_d = guessed_mask;
    lives_d = lives;
    pulse_d = '0;
    is_start = load_x == LW'(NUM_LETTERS);
    if (load && is_start) begin
      if (|mask) begin
        state_d = INGAME;
        word_d = mask;
        guessed_d = '0;
        lives_d = CW'(MAX_WRONG);
      end else pulse_d = 4'b0001;
    end else if (load) begin
      pulse_d = result == HIT ? 4'b1000 : result == MISS ? 4'b0100 : result == REPEAT ? 4'b0010 : 4'b0001;
      if (result == HIT || result == MISS) guessed_d = next_guessed;
      if (result == HIT && win_next) state_d = WINGAME;
      if (result == MISS) lives_d = lives - CW'(1);
      if (result == MISS && lose_next) state_d = LOSTGAME;
    end
  end
  assign game_state = state;
  assign reveal_mask = word_mask & guessed_mask;
  assign {hit, miss, repeat_guess, bad_cmd} = pulse;
endmodule

// File: tb/tb_hangman_game_ctrl.sv
// tb_hangman_game_ctrl: directed checks of the default build and a MAX_WRONG=2 build
module tb_hangman_game_ctrl;
  logic clk = 0, reset = 0;
  logic load = 0, load_b = 0;
  logic [4:0] load_x = 0, load_x_b = 0;
  logic [25:0] mask = 0, mask_b = 0;
  logic [1:0] gs, gs_b;
  logic [25:0] gm, rm, gm_b, rm_b;
  logic [3:0] lv;
  logic [1:0] lv_b;
  logic h, m, r, b, h_b, m_b, r_b, b_b;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  hangman_game_ctrl dut (
    .clk(clk), .reset(reset), .load(load), .load_x(load_x), .mask(mask),
    .game_state(gs), .guessed_mask(gm), .reveal_mask(rm), .lives(lv),
    .hit(h), .miss(m), .repeat_guess(r), .bad_cmd(b)
  );
  hangman_game_ctrl #(.MAX_WRONG(2)) dut_b (
    .clk(clk), .reset(reset), .load(load_b), .load_x(load_x_b), .mask(mask_b),
    .game_state(gs_b), .guessed_mask(gm_b), .reveal_mask(rm_b), .lives(lv_b),
    .hit(h_b), .miss(m_b), .repeat_guess(r_b), .bad_cmd(b_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [4:0] x, input logic [25:0] mk);
    load = 1; load_x = x; mask = mk;
    @(posedge clk); #1;
    load = 0; mask = 26'h3ffffff;
  endtask

  task automatic cmd_b(input logic [4:0] x, input logic [25:0] mk);
    load_b = 1; load_x_b = x; mask_b = mk;
    @(posedge clk); #1;
    load_b = 0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1; idle(); idle(); reset = 0;
    chk("rst_state", gs, 0);
    chk("rst_guessed", gm, 0);
    chk("rst_lives", lv, 10);
    chk("rst_pulses", {h, m, r, b}, 0);
    chk("rst_reveal", rm, 0);
    chk("rst_b_lives", lv_b, 2);

    cmd(26, 26'h0000011);
    chk("start_state", gs, 1);
    chk("start_pulses", {h, m, r, b}, 0);
    cmd(0, 0);
    chk("hit_a", {h, m, r, b}, 4'b1000);
    chk("hit_a_state", gs, 1);
    cmd(4, 0);
    chk("hit_e", {h, m, r, b}, 4'b1000);
    chk("win_state", gs, 2);
    chk("win_lives", lv, 10);
    chk("win_reveal", rm, 26'h0000011);
    idle();
    chk("pulse_clear", {h, m, r, b}, 0);
    cmd(0, 0);
    chk("guess_in_win", {h, m, r, b}, 4'b0001);
    chk("guess_in_win_state", gs, 2);

    cmd(26, 26'h0000001);
    cmd(1, 0);
    chk("miss_b", {h, m, r, b}, 4'b0100);
    chk("miss_b_lives", lv, 9);
    cmd(1, 0);
    chk("repeat_b", {h, m, r, b}, 4'b0010);
    chk("repeat_b_lives", lv, 9);
    chk("repeat_b_guessed", gm, 26'h0000002);
    chk("repeat_b_state", gs, 1);

    cmd_b(26, 26'h0000001);
    cmd_b(25, 0);
    chk("b_miss_z", {h_b, m_b, r_b, b_b}, 4'b0100);
    chk("b_lives1", lv_b, 1);
    chk("b_state_in", gs_b, 1);
    cmd_b(24, 0);
    chk("b_miss_y", {h_b, m_b, r_b, b_b}, 4'b0100);
    chk("b_lives0", lv_b, 0);
    chk("b_lost", gs_b, 3);
    cmd_b(0, 0);
    chk("b_bad_after_lost", {h_b, m_b, r_b, b_b}, 4'b0001);
    chk("b_lost_state", gs_b, 3);
    chk("b_lost_lives", lv_b, 0);

    reset = 1; idle(); reset = 0;
    cmd(26, 0);
    chk("start_zero_bad", {h, m, r, b}, 4'b0001);
    chk("start_zero_state", gs, 0);
    for (int x = 27; x <= 31; x++) begin
      cmd(5'(x), 26'h1);
      chk("unused_code_bad", {h, m, r, b}, 4'b0001);
      chk("unused_code_state", gs, 0);
    end
    cmd(3, 0);
    chk("letter_in_start", {h, m, r, b}, 4'b0001);

    cmd(26, 26'h0000001);
    cmd(1, 0); cmd(2, 0); cmd(3, 0);
    chk("three_miss_lives", lv, 7);
    cmd(26, 26'h2000000);
    chk("restart_state", gs, 1);
    chk("restart_lives", lv, 10);
    chk("restart_guessed", gm, 0);
    chk("restart_pulses", {h, m, r, b}, 0);
    cmd(25, 0);
    chk("restart_hit_z", {h, m, r, b}, 4'b1000);
    chk("restart_win", gs, 2);
    chk("restart_reveal", rm, 26'h2000000);

    cmd(26, 26'h0000001);
    reset = 1; load = 1; load_x = 1;
    idle();
    reset = 0; load = 0;
    chk("rst_load_state", gs, 0);
    chk("rst_load_lives", lv, 10);
    chk("rst_load_guessed", gm, 0);
    chk("rst_load_pulses", {h, m, r, b}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
